// File: rtl/fifo_pixel_unpacker_pkg.sv
// rtl/fifo_pixel_unpacker_pkg.sv - shared constants and helpers for the pixel packer/unpacker pair
//
// Purpose : common truth constants, a constant-foldable clog2, and the lane
//           slice offset helper used to address pixel k inside a packed word.
package fifo_pixel_unpacker_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Ceiling log2; callers only pass values >= 2, so the result is >= 1.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // LSB position of lane k in a word of width-bit lanes (lane 0 at the LSBs).
  function automatic int lane_slice_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/fifo_pixel_unpacker.sv
// rtl/fifo_pixel_unpacker.sv - unpacks LANES-wide FIFO words into a one-pixel-per-cycle stream
//
// Purpose : pops packed words from a first-word-fall-through FIFO and emits
//           their pixels lane 0 first on a registered valid/ready stream,
//           tagged with start/end-of-line from a free-running pixel counter.
// Ports   :
//   CLK         in   clock, all state on posedge
//   RESET_N     in   asynchronous active-low reset
//   fifo_empty  in   upstream FIFO empty; fifo_dout valid when low
//   fifo_dout   in   upstream head word, lane k at [k*PIX_WIDTH +: PIX_WIDTH]
//   fifo_rden   out  combinational pop strobe
//   out_ready   in   downstream accepts current pixel
//   out_valid   out  registered pixel valid
//   out_data    out  registered pixel
//   out_sol     out  registered start-of-line
//   out_eol     out  registered end-of-line
//   busy        out  a word is held or a pixel is pending
module fifo_pixel_unpacker
  import fifo_pixel_unpacker_pkg::*;
#(
  parameter int DELAY       = 1,
  parameter int PIX_WIDTH   = 16,
  parameter int LANES       = 4,
  parameter int LINE_PIXELS = 8
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       fifo_empty,
  input  logic [PIX_WIDTH*LANES-1:0] fifo_dout,
  output logic                       fifo_rden,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [PIX_WIDTH-1:0]       out_data,
  output logic                       out_sol,
  output logic                       out_eol,
  output logic                       busy
);

  localparam int LANE_W = clog2(LANES);
  localparam int CNT_W  = clog2(LINE_PIXELS);

  // DELAY exists only so simulation wrappers can pass it through; the
  // registered logic itself is written delay-free.
  if (DELAY < 0) begin : g_bad_delay
    $error("DELAY must be non-negative");
  end
  if ((LANES < 2) || ((LANES & (LANES - 1)) != 0)) begin : g_bad_lanes
    $error("LANES must be a power of two >= 2");
  end
  if ((LINE_PIXELS < LANES) || ((LINE_PIXELS % LANES) != 0)) begin : g_bad_line
    $error("LINE_PIXELS must be a multiple of LANES");
  end

  logic [PIX_WIDTH*LANES-1:0] hold;
  logic                       hold_valid;
  logic [LANE_W-1:0]          lane;
  logic [CNT_W-1:0]           pix_cnt;

  logic adv;
  logic last_lane;

  // A slot advances when a word is held and the output register is free or
  // being drained this cycle.
  assign adv       = hold_valid && (!out_valid || out_ready);
  assign last_lane = (lane == LANE_W'(LANES - 1));

  // Refill when the hold is empty, or exactly when its last lane moves out,
  // so consecutive words stream without a bubble. Gated by reset so the
  // strobe is quiet while the block is held in reset.
  assign fifo_rden = RESET_N && !fifo_empty && (!hold_valid || (adv && last_lane));

  assign busy = hold_valid || out_valid;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hold       <= '0;
      hold_valid <= FALSE;
      lane       <= '0;
      pix_cnt    <= '0;
      out_valid  <= FALSE;
      out_data   <= '0;
      out_sol    <= FALSE;
      out_eol    <= FALSE;
    end else begin
      // Refill wins over draining the last lane in the same cycle.
      if (fifo_rden) begin
        hold       <= fifo_dout;
        hold_valid <= TRUE;
        lane       <= '0;
      end else if (adv) begin
        lane <= lane + LANE_W'(1);
        if (last_lane) begin
          hold_valid <= FALSE;
        end
      end

      if (adv) begin
        out_data  <= hold[lane_slice_lsb(int'(lane), PIX_WIDTH) +: PIX_WIDTH];
        out_valid <= TRUE;
        out_sol   <= (pix_cnt == '0);
        out_eol   <= (pix_cnt == CNT_W'(LINE_PIXELS - 1));
        if (pix_cnt == CNT_W'(LINE_PIXELS - 1)) begin
          pix_cnt <= '0;
        end else begin
          pix_cnt <= pix_cnt + CNT_W'(1);
        end
      end else if (out_valid && out_ready) begin
        out_valid <= FALSE;
      end
    end
  end

endmodule

// File: tb/tb_fifo_pixel_unpacker.sv
// tb/tb_fifo_pixel_unpacker.sv - self-checking bench for fifo_pixel_unpacker
module tb_fifo_pixel_unpacker;

  localparam int PW = 16;
  localparam int LN = 4;
  localparam int LP = 8;

  logic             CLK = 1'b0;
  logic             RESET_N = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [PW*LN-1:0] fifo_dout = '0;
  logic             fifo_rden;
  logic             out_ready = 1'b1;
  logic             out_valid;
  logic [PW-1:0]    out_data;
  logic             out_sol;
  logic             out_eol;
  logic             busy;

  fifo_pixel_unpacker #(
    .DELAY(1), .PIX_WIDTH(PW), .LANES(LN), .LINE_PIXELS(LP)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rden(fifo_rden), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_sol(out_sol), .out_eol(out_eol), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [PW-1:0] d;
    logic          sol;
    logic          eol;
  } pix_t;

  logic [PW*LN-1:0] fifo_q[$];
  logic [PW-1:0]    exp_q[$];
  pix_t             got[$];
  logic [PW-1:0]    pop_view[$];
  logic             pop_view_v[$];

  int checks = 0;
  int errors = 0;
  int n = 0;
  int pops = 0;
  bit prev_stall = 0;
  logic [PW-1:0] prev_d;
  logic prev_sol, prev_eol;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic push_word(input logic [PW*LN-1:0] w);
    fifo_q.push_back(w);
    for (int k = 0; k < LN; k++) exp_q.push_back(w[k*PW +: PW]);
    refresh();
  endtask

  function automatic logic [PW*LN-1:0] mkword(input int base);
    logic [PW*LN-1:0] w;
    for (int k = 0; k < LN; k++) w[k*PW +: PW] = PW'(base + k + 1);
    return w;
  endfunction

  // Upstream FIFO model: pop the head after the edge that saw fifo_rden.
  always @(posedge CLK) begin
    if (fifo_rden) begin
      pops++;
      pop_view.push_back(out_data);
      pop_view_v.push_back(out_valid);
      #1;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      refresh();
    end
  end

  // Scoreboard: every accepted pixel must be the next expected one, with
  // line flags derived from its index since reset.
  always @(negedge CLK) begin
    if (RESET_N) begin
      if (fifo_empty) chk("rden_when_empty", fifo_rden, 0);
      if (out_valid) chk("busy_with_valid", busy, 1);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_d);
        chk("stall_sol", out_sol, prev_sol);
        chk("stall_eol", out_eol, prev_eol);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel actual=%0h required=none", out_data);
        end else begin
          chk("pix_data", out_data, exp_q.pop_front());
          chk("pix_sol", out_sol, (n % LP) == 0);
          chk("pix_eol", out_eol, (n % LP) == LP - 1);
          n++;
          got.push_back('{out_data, out_sol, out_eol});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_sol   = out_sol;
      prev_eol   = out_eol;
    end
  end

  task automatic do_reset();
    @(posedge CLK); #2;
    RESET_N = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    n = 0;
    prev_stall = 0;
    refresh();
    @(posedge CLK); #2;
    RESET_N = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || busy) && c < 500) begin
      @(negedge CLK); #1;
      c++;
    end
    chk(name, c < 500, 1);
  endtask

  task automatic wait_valid(input string name);
    int c;
    c = 0;
    while (!out_valid && c < 20) begin
      @(negedge CLK); #1;
      c++;
    end
    chk(name, out_valid, 1);
  endtask

  initial begin
    int g0, g1, p0, c, sent;

    // Reset state, with a word already waiting upstream.
    RESET_N = 1'b0;
    push_word(mkword(0));
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sol", out_sol, 0);
    chk("rst_eol", out_eol, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rden", fifo_rden, 0);
    fifo_q.delete();
    exp_q.delete();
    refresh();
    @(posedge CLK); #2;
    RESET_N = 1'b1;

    // Single word: latency and one-cycle pop pulse.
    repeat (2) @(posedge CLK);
    @(posedge CLK); #2;
    p0 = pops;
    push_word(64'h0004_0003_0002_0001);
    @(negedge CLK); #1;
    chk("t1_rden_t", fifo_rden, 1);
    chk("t1_valid_t", out_valid, 0);
    @(negedge CLK); #1;
    chk("t1_rden_t1", fifo_rden, 0);
    chk("t1_valid_t1", out_valid, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK); #1;
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, i);
      chk("t1_sol", out_sol, i == 1);
    end
    @(negedge CLK); #1;
    chk("t1_valid_drop", out_valid, 0);
    chk("t1_pops", pops - p0, 1);

    // Four back-to-back words: 16 gapless pixels, refill on lane 3.
    do_reset();
    g0 = got.size();
    p0 = pops;
    for (int w = 0; w < 4; w++) push_word(mkword(w * 16));
    wait_valid("t2_start");
    c = 0;
    while (out_valid && c < 40) begin
      c++;
      @(negedge CLK); #1;
    end
    chk("t2_contig", c, 16);
    chk("t2_pops", pops - p0, 4);
    chk("t2_pop2_data", pop_view[p0 + 1], 3);
    chk("t2_pop2_valid", pop_view_v[p0 + 1], 1);
    chk("t2_sol1", got[g0].sol, 1);
    chk("t2_sol9", got[g0 + 8].sol, 1);
    chk("t2_sol5", got[g0 + 4].sol, 0);
    chk("t2_eol8", got[g0 + 7].eol, 1);
    chk("t2_eol16", got[g0 + 15].eol, 1);
    chk("t2_data16", got[g0 + 15].d, 16'h34);

    // Five-cycle stall while lane 1 is on the output.
    do_reset();
    g0 = got.size();
    push_word(mkword(0));
    c = 0;
    do begin
      @(posedge CLK); #2;
      c++;
    end while (!(out_valid && out_data == 2) && c < 20);
    chk("t3_found", out_data, 2);
    out_ready = 1'b0;
    p0 = pops;
    repeat (5) begin
      @(negedge CLK); #1;
      chk("t3_hold_data", out_data, 2);
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_no_rden", fifo_rden, 0);
    end
    chk("t3_pops", pops - p0, 0);
    @(posedge CLK); #2;
    out_ready = 1'b1;
    wait_drain("t3_drain");
    chk("t3_count", got.size() - g0, 4);
    chk("t3_p3", got[g0 + 2].d, 3);
    chk("t3_p4", got[g0 + 3].d, 4);

    // Upstream gap: line framing carries across.
    do_reset();
    g0 = got.size();
    push_word(mkword(16'h100));
    repeat (10) @(posedge CLK);
    #2;
    chk("t4_gap", out_valid, 0);
    push_word(mkword(16'h200));
    wait_drain("t4_drain");
    chk("t4_p5_data", got[g0 + 4].d, 16'h201);
    chk("t4_p5_sol", got[g0 + 4].sol, 0);
    chk("t4_p5_eol", got[g0 + 4].eol, 0);
    chk("t4_p8_eol", got[g0 + 7].eol, 1);

    // Asynchronous reset mid-word.
    do_reset();
    g0 = got.size();
    push_word(mkword(16'h300));
    c = 0;
    while (got.size() < g0 + 2 && c < 20) begin
      @(negedge CLK); #2;
      c++;
    end
    chk("t5_reached", got.size() - g0, 2);
    RESET_N = 1'b0;
    exp_q.delete();
    n = 0;
    prev_stall = 0;
    #1;
    chk("t5_valid", out_valid, 0);
    chk("t5_data", out_data, 0);
    chk("t5_sol", out_sol, 0);
    chk("t5_eol", out_eol, 0);
    chk("t5_busy", busy, 0);
    push_word(mkword(16'h400));
    #1;
    chk("t5_rden", fifo_rden, 0);
    g1 = got.size();
    @(posedge CLK); #2;
    RESET_N = 1'b1;
    wait_drain("t5_drain");
    chk("t5_count", got.size() - g1, 4);
    chk("t5_first", got[g1].d, 16'h401);
    chk("t5_first_sol", got[g1].sol, 1);

    // Random data, random ready, random upstream arrival.
    do_reset();
    g0 = got.size();
    sent = 0;
    c = 0;
    while ((sent < 64 || exp_q.size() != 0 || busy) && c < 4000) begin
      @(posedge CLK); #2;
      c++;
      out_ready = ($urandom_range(0, 1) == 1);
      if (sent < 64 && $urandom_range(0, 3) != 0) begin
        push_word({$urandom, $urandom});
        sent++;
      end
    end
    out_ready = 1'b1;
    chk("rand_timeout", c < 4000, 1);
    chk("rand_count", got.size() - g0, 256);
    chk("rand_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
